ppfifo_source: RTL and testbench

//  Upstream producer for a ping-pong FIFO write side. Whenever enabled and a write

---
 rtl/ppfifo_pkg.sv | 30 +++
 rtl/ppfifo_pattern_gen.sv | 48 ++++
 rtl/ppfifo_source.sv | 101 ++++++++++
 tb/tb_ppfifo_source.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ppfifo_pkg.sv
// Shared definitions for the ping-pong FIFO source: pattern modes, FSM states,
// LFSR constants and burst-limit helper.
package ppfifo_pkg;

    localparam int unsigned PPF_SIZE_WIDTH = 24;

    typedef enum logic [1:0] {
        PPF_MODE_INCR  = 2'd0,
        PPF_MODE_LFSR  = 2'd1,
        PPF_MODE_FIXED = 2'd2,
        PPF_MODE_WALK  = 2'd3
    } ppf_mode_t;

    typedef enum logic {
        PPF_ST_IDLE,
        PPF_ST_FILL
    } ppf_state_t;

    // x^32 + x^22 + x^2 + x + 1 -> state bits 31, 21, 1, 0 feed back
    localparam logic [31:0] PPF_LFSR_TAPS         = 32'h8020_0003;
    localparam logic [31:0] PPF_LFSR_SEED_DEFAULT = 32'hACE1_0001;

    function automatic logic [PPF_SIZE_WIDTH-1:0] ppf_limit(
        input logic [PPF_SIZE_WIDTH-1:0] max_len,
        input logic [PPF_SIZE_WIDTH-1:0] size
    );
        return ((max_len == '0) || (max_len > size)) ? size : max_len;
    endfunction

endpackage

// File: rtl/ppfifo_pattern_gen.sv
// Test-pattern generator; each mode keeps its own state so streams continue
// across bursts, reloading on rst or reload.
module ppfifo_pattern_gen
    import ppfifo_pkg::*;
#(
    parameter int unsigned     DATA_WIDTH = 8,
    parameter logic [31:0]     LFSR_SEED  = PPF_LFSR_SEED_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reload,
    input  ppf_mode_t             mode,
    input  logic [DATA_WIDTH-1:0] fixed,
    input  logic                  advance,
    output logic [DATA_WIDTH-1:0] data
);

    logic [DATA_WIDTH-1:0] incr_q;
    logic [DATA_WIDTH-1:0] walk_q;
    logic [31:0]           lfsr_q;

    always_ff @(posedge clk) begin
        if (rst || reload) begin
            incr_q <= '0;
            walk_q <= DATA_WIDTH'(1);
            lfsr_q <= LFSR_SEED;
        end else if (advance) begin
            case (mode)
                PPF_MODE_INCR: incr_q <= incr_q + 1'b1;
                PPF_MODE_LFSR: lfsr_q <= {lfsr_q[30:0], ^(lfsr_q & PPF_LFSR_TAPS)};
                PPF_MODE_WALK: walk_q <= (walk_q << 1) | (walk_q >> (DATA_WIDTH - 1));
                default: ;
            endcase
        end
    end

    always_comb begin
        data = '0;
        case (mode)
            PPF_MODE_INCR:  data = incr_q;
            PPF_MODE_LFSR:  data = lfsr_q[DATA_WIDTH-1:0];
            PPF_MODE_FIXED: data = fixed;
            PPF_MODE_WALK:  data = walk_q;
            default:        data = '0;
        endcase
    end

endmodule

// File: rtl/ppfifo_source.sv
// Ping-pong FIFO write-side producer: claims a free buffer, fills it with a
// generated pattern up to a latched limit, then releases it.
module ppfifo_source
    import ppfifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter logic [31:0] LFSR_SEED  = PPF_LFSR_SEED_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_enable,
    input  logic [1:0]                i_mode,
    input  logic [DATA_WIDTH-1:0]     i_fixed_value,
    input  logic [PPF_SIZE_WIDTH-1:0] i_max_len,
    input  logic [1:0]                i_wr_rdy,
    output logic [1:0]                o_wr_act,
    input  logic [PPF_SIZE_WIDTH-1:0] i_wr_size,
    output logic                      o_wr_stb,
    output logic [DATA_WIDTH-1:0]     o_wr_data,
    output logic                      o_busy,
    output logic [31:0]               o_words_sent
);

    ppf_state_t                state, state_next;
    ppf_mode_t                 mode_q;
    logic [DATA_WIDTH-1:0]     fixed_q;
    logic [PPF_SIZE_WIDTH-1:0] count, limit;
    logic                      enable_q;
    logic                      start, advance, reload;
    logic [DATA_WIDTH-1:0]     pattern;

    assign start   = i_enable && (i_wr_rdy != 2'b00) && (o_wr_act == 2'b00);
    assign advance = (state == PPF_ST_FILL) && (count < limit);
    assign reload  = i_enable && !enable_q;

    ppfifo_pattern_gen #(
        .DATA_WIDTH (DATA_WIDTH),
        .LFSR_SEED  (LFSR_SEED)
    ) u_pattern (
        .clk     (clk),
        .rst     (rst),
        .reload  (reload),
        .mode    (mode_q),
        .fixed   (fixed_q),
        .advance (advance),
        .data    (pattern)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= PPF_ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            PPF_ST_IDLE: if (start)    state_next = PPF_ST_FILL;
            PPF_ST_FILL: if (!advance) state_next = PPF_ST_IDLE;
            default:                   state_next = PPF_ST_IDLE;
        endcase
    end

    always_comb begin
        o_busy = (state != PPF_ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_wr_act     <= '0;
            o_wr_stb     <= 1'b0;
            o_wr_data    <= '0;
            o_words_sent <= '0;
            count        <= '0;
            limit        <= '0;
            mode_q       <= PPF_MODE_INCR;
            fixed_q      <= '0;
            enable_q     <= 1'b0;
        end else begin
            enable_q <= i_enable;
            o_wr_stb <= 1'b0;
            if (state == PPF_ST_IDLE) begin
                if (start) begin
                    // buffer 0 wins when both are free
                    o_wr_act <= i_wr_rdy[0] ? 2'b01 : 2'b10;
                    limit    <= ppf_limit(i_max_len, i_wr_size);
                    mode_q   <= ppf_mode_t'(i_mode);
                    fixed_q  <= i_fixed_value;
                    count    <= '0;
                end
            end else if (advance) begin
                o_wr_stb     <= 1'b1;
                o_wr_data    <= pattern;
                count        <= count + 1'b1;
                o_words_sent <= o_words_sent + 1'b1;
            end else begin
                o_wr_act <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ppfifo_source.sv
// Scoreboard bench for ppfifo_source: a behavioural pattern model predicts each
// burst's words; a negedge monitor compares every strobe against the queue.
module tb_ppfifo_source;

    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_enable;
    logic [1:0]    i_mode;
    logic [DW-1:0] i_fixed_value;
    logic [23:0]   i_max_len;
    logic [1:0]    i_wr_rdy;
    logic [1:0]    o_wr_act;
    logic [23:0]   i_wr_size;
    logic          o_wr_stb;
    logic [DW-1:0] o_wr_data;
    logic          o_busy;
    logic [31:0]   o_words_sent;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] exp_q[$];
    int unsigned   m_incr;
    logic [31:0]   m_lfsr;
    logic [DW-1:0] m_walk;
    logic [31:0]   total;
    bit            en_prev;

    ppfifo_source #(
        .DATA_WIDTH (DW),
        .LFSR_SEED  (32'hACE1_0001)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_enable      (i_enable),
        .i_mode        (i_mode),
        .i_fixed_value (i_fixed_value),
        .i_max_len     (i_max_len),
        .i_wr_rdy      (i_wr_rdy),
        .o_wr_act      (o_wr_act),
        .i_wr_size     (i_wr_size),
        .o_wr_stb      (o_wr_stb),
        .o_wr_data     (o_wr_data),
        .o_busy        (o_busy),
        .o_words_sent  (o_words_sent)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic model_reload();
        m_incr = 0;
        m_lfsr = 32'hACE1_0001;
        m_walk = 8'h01;
    endtask

    task automatic model_next(input int mode, input logic [DW-1:0] fixed, output logic [DW-1:0] w);
        logic fb;
        case (mode)
            0: begin w = DW'(m_incr % 256); m_incr = (m_incr + 1) % 256; end
            1: begin
                w = m_lfsr[DW-1:0];
                fb = m_lfsr[31] ^ m_lfsr[21] ^ m_lfsr[1] ^ m_lfsr[0];
                m_lfsr = {m_lfsr[30:0], fb};
            end
            2: w = fixed;
            default: begin w = m_walk; m_walk = (m_walk == 8'h80) ? 8'h01 : (m_walk << 1); end
        endcase
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            check("act_onehot", 32'(o_wr_act == 2'b11), 32'd0);
            if (o_wr_stb) begin
                if (exp_q.size() == 0) check("unexpected_stb", 32'(o_wr_stb), 32'd0);
                else check("data", 32'(o_wr_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic run_burst(input int mode, input logic [DW-1:0] fixed, input int max_len,
                             input int size, input logic [1:0] rdy, input int drop_at,
                             input int rst_at, input bit toggle);
        int lim;
        logic [1:0] sel;
        bit got;
        logic [DW-1:0] w;
        @(posedge clk); #1;
        if (toggle && en_prev) begin
            i_enable = 1'b0;
            en_prev = 1'b0;
            repeat (3) @(posedge clk);
            #1;
        end
        i_mode = mode[1:0];
        i_fixed_value = fixed;
        i_max_len = 24'(max_len);
        i_wr_size = 24'(size);
        i_wr_rdy = rdy;
        if (!en_prev) begin model_reload(); en_prev = 1'b1; end
        i_enable = 1'b1;
        sel = rdy[0] ? 2'b01 : 2'b10;
        lim = (max_len == 0 || max_len > size) ? size : max_len;
        got = 1'b0;
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge clk);
            if (o_wr_act != 2'b00) got = 1'b1;
        end
        if (!got) begin
            check("act_timeout", 32'(o_wr_act), 32'(sel));
            return;
        end
        check("act_sel", 32'(o_wr_act), 32'(sel));
        check("stb_at_act", 32'(o_wr_stb), 32'd0);
        check("busy_at_act", 32'(o_busy), 32'd1);
        for (int i = 0; i < lim; i++) begin
            model_next(mode, fixed, w);
            exp_q.push_back(w);
        end
        #1;
        i_wr_rdy = 2'b00;
        i_mode = 2'($urandom);
        i_fixed_value = DW'($urandom);
        for (int k = 1; k <= lim + 1; k++) begin
            @(negedge clk);
            if (k <= lim) begin
                check("stb_in_burst", 32'(o_wr_stb), 32'd1);
                check("act_hold", 32'(o_wr_act), 32'(sel));
                check("busy_fill", 32'(o_busy), 32'd1);
            end else begin
                check("act_release", 32'(o_wr_act), 32'd0);
                check("stb_after", 32'(o_wr_stb), 32'd0);
                check("busy_idle", 32'(o_busy), 32'd0);
            end
            if (k == rst_at) begin
                #1 rst = 1'b1;
                @(negedge clk);
                check("rst_act", 32'(o_wr_act), 32'd0);
                check("rst_stb", 32'(o_wr_stb), 32'd0);
                check("rst_words", o_words_sent, 32'd0);
                exp_q.delete();
                model_reload();
                total = 0;
                #1 rst = 1'b0;
                return;
            end
            if (k == drop_at) begin
                #1;
                i_enable = 1'b0;
                en_prev = 1'b0;
                i_wr_rdy = 2'b11;
            end
        end
        total += 32'(lim);
        check("words_sent", o_words_sent, total);
        if (drop_at > 0) begin
            repeat (5) begin
                @(negedge clk);
                check("no_new_act", 32'(o_wr_act), 32'd0);
            end
            #1 i_wr_rdy = 2'b00;
        end
    endtask

    initial begin
        rst = 1'b1;
        i_enable = 1'b0;
        i_mode = 2'd0;
        i_fixed_value = '0;
        i_max_len = '0;
        i_wr_rdy = 2'b00;
        i_wr_size = '0;
        total = 0;
        en_prev = 1'b0;
        model_reload();
        repeat (3) @(negedge clk);
        check("reset_act", 32'(o_wr_act), 32'd0);
        check("reset_stb", 32'(o_wr_stb), 32'd0);
        check("reset_data", 32'(o_wr_data), 32'd0);
        check("reset_busy", 32'(o_busy), 32'd0);
        check("reset_words", o_words_sent, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        run_burst(0, 8'h00, 0, 16, 2'b11, -1, -1, 1'b0);
        run_burst(0, 8'h00, 0, 16, 2'b10, -1, -1, 1'b0);
        run_burst(0, 8'h00, 5, 16, 2'b11, -1, -1, 1'b0);
        run_burst(0, 8'h00, 20, 16, 2'b01, -1, -1, 1'b0);
        run_burst(3, 8'h00, 10, 16, 2'b11, -1, -1, 1'b0);
        run_burst(2, 8'hA5, 0, 8, 2'b10, -1, -1, 1'b0);
        run_burst(1, 8'h00, 0, 12, 2'b11, -1, -1, 1'b0);
        run_burst(0, 8'h00, 0, 0, 2'b11, -1, -1, 1'b0);
        run_burst(0, 8'h00, 3, 0, 2'b10, -1, -1, 1'b0);
        run_burst(0, 8'h00, 0, 16, 2'b11, 3, -1, 1'b0);
        run_burst(0, 8'h00, 0, 16, 2'b11, -1, 7, 1'b0);
        run_burst(0, 8'h00, 0, 4, 2'b01, -1, -1, 1'b0);

        for (int n = 0; n < 40; n++) begin
            run_burst(int'($urandom_range(0, 3)), DW'($urandom), ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 25)),
                      int'($urandom_range(0, 20)), 2'($urandom_range(1, 3)), -1, -1, $urandom_range(0, 3) == 0);
        end

        repeat (5) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
